// File: rtl/ftoi_arb_pkg.sv
// Shared types and constants for the two-requester float-to-int arbiter.
// The overflow helper here is only referenced when FTOI_ARB_OVF_EN is defined.
package ftoi_arb_pkg;

  localparam int NUM_REQ = 2;

  // Biased exponent at and above which the magnitude no longer fits in int32.
  localparam logic [7:0] EXP_OVF = 8'd158;

  // Biased exponent of 1.0; anything below truncates to zero.
  localparam logic [7:0] EXP_ONE = 8'd127;

  // Bit pattern of -2^31, the one representable value at EXP_OVF.
  localparam logic [31:0] FP_INT_MIN = 32'hCF00_0000;

  typedef logic req_id_t;

  typedef struct packed {
    logic [31:0] data;
    req_id_t     id;
    logic        ovf;
  } result_t;

  // Out-of-range detection for a single-precision operand.
  function automatic logic ovf_check(input logic [31:0] f);
    return (f[30:23] >= EXP_OVF) && (f != FP_INT_MIN);
  endfunction

endpackage

// File: rtl/ftoi.sv
// Combinational IEEE-754 single to signed int32 conversion, truncating toward zero.
// Out-of-range inputs produce the magnitude pattern 1.mant<<31 (no saturation flag here).
module ftoi
  import ftoi_arb_pkg::*;
(
  input  logic [31:0] fp_in,
  output logic [31:0] int_out
);

  logic [7:0]  exp_f;
  logic [7:0]  rsh;
  logic [31:0] mag;

  assign exp_f = fp_in[30:23];

  // Place 1.mant at bit 31 and shift right so only the integer part remains.
  always_comb begin
    rsh = 8'd0;
    mag = 32'd0;
    if (exp_f >= EXP_ONE) begin
      rsh = (exp_f >= EXP_OVF) ? 8'd0 : (EXP_OVF - exp_f);
      mag = {1'b1, fp_in[22:0], 8'd0} >> rsh;
    end
  end

  assign int_out = fp_in[31] ? (~mag + 32'd1) : mag;

endmodule

// File: rtl/ftoi_arbiter.sv
// Round-robin arbiter sharing one ftoi converter between two requesters,
// followed by a single full-throughput result register.
// FTOI_ARB_OVF_EN: when defined, resp_ovf reports out-of-range operands;
// when undefined, resp_ovf is constant 0.
module ftoi_arbiter
  import ftoi_arb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][31:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [31:0]                resp_data,
  output logic                       resp_id,
  output logic                       resp_ovf
);

  logic        valid_reg;
  result_t     res_reg;
  result_t     res_next;
  req_id_t     ptr_reg;
  req_id_t     gnt_id;
  logic        accept;
  logic        xfer;
  logic [31:0] conv_in;
  logic [31:0] conv_out;

  // Register slot is free when empty or being drained this cycle.
  assign accept = !valid_reg || resp_ready;
  assign xfer   = !rst && accept && (|req_valid);

  // Grant the lone valid requester, or the pointer's choice under contention.
  always_comb begin
    gnt_id = ptr_reg;
    case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = ptr_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = !rst && accept && req_valid[gi] &&
                             (gnt_id == req_id_t'(gi));
    end
  endgenerate

  assign conv_in = req_data[gnt_id];

  ftoi u_ftoi (
    .fp_in   (conv_in),
    .int_out (conv_out)
  );

  // Assemble the record to be captured on a transfer.
  always_comb begin
    res_next.data = conv_out;
    res_next.id   = gnt_id;
`ifdef FTOI_ARB_OVF_EN
    res_next.ovf  = ovf_check(conv_in);
`else
    res_next.ovf  = 1'b0;
`endif
  end

  // Result register, valid flag and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      res_reg   <= '0;
      ptr_reg   <= 1'b0;
    end else if (accept) begin
      valid_reg <= |req_valid;
      if (xfer) begin
        res_reg <= res_next;
        ptr_reg <= ~gnt_id;
      end
    end
  end

  assign resp_valid = valid_reg;
  assign resp_data  = res_reg.data;
  assign resp_id    = res_reg.id;
  assign resp_ovf   = res_reg.ovf;

endmodule

// File: tb/tb_ftoi_arbiter.sv
// Directed self-checking bench for ftoi_arbiter.
module tb_ftoi_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_data;
  logic [1:0]       req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic             resp_id;
  logic             resp_ovf;

  int checks;
  int failures;

  ftoi_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ovf   (resp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef FTOI_ARB_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  // Single-request vectors on requester 1: operand, expected int, expected ovf.
  logic [31:0] vec_in  [6];
  logic [31:0] vec_out [6];
  logic        vec_ovf [6];

  initial begin
    vec_in[0] = 32'hBFC0_0000; vec_out[0] = 32'hFFFF_FFFF; vec_ovf[0] = 1'b0;
    vec_in[1] = 32'h4070_0000; vec_out[1] = 32'h0000_0003; vec_ovf[1] = 1'b0;
    vec_in[2] = 32'h3F00_0000; vec_out[2] = 32'h0000_0000; vec_ovf[2] = 1'b0;
    vec_in[3] = 32'hCF00_0000; vec_out[3] = 32'h8000_0000; vec_ovf[3] = 1'b0;
    vec_in[4] = 32'h4F00_0000; vec_out[4] = 32'h8000_0000; vec_ovf[4] = OVF_EXP;
    vec_in[5] = 32'hC2F6_0000; vec_out[5] = 32'hFFFF_FF85; vec_ovf[5] = 1'b0;
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_data   = '0;
    resp_ready = 1'b1;

    // Reset state, with both requesters valid to confirm ready stays low.
    step();
    step();
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", {31'd0, resp_id}, 32'd0);
    check("rst_resp_ovf", {31'd0, resp_ovf}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    step();

    // Single request on requester 0: 1.0 -> 1.
    req_valid   = 2'b01;
    req_data[0] = 32'h3F80_0000;
    #1;
    check("single_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check("single_valid", {31'd0, resp_valid}, 32'd1);
    check("single_data", resp_data, 32'd1);
    check("single_id", {31'd0, resp_id}, 32'd0);

    // Conversion vectors through requester 1.
    for (int k = 0; k < 6; k++) begin
      req_valid   = 2'b10;
      req_data[1] = vec_in[k];
      step();
      req_valid = 2'b00;
      check($sformatf("conv%0d_data", k), resp_data, vec_out[k]);
      check($sformatf("conv%0d_id", k), {31'd0, resp_id}, 32'd1);
      check($sformatf("conv%0d_ovf", k), {31'd0, resp_ovf}, {31'd0, vec_ovf[k]});
    end

    // Idle cycle with resp_ready high drains the register.
    step();
    check("drain_valid", {31'd0, resp_valid}, 32'd0);

    // Fresh reset, then sustained contention: ids alternate 0,1,0,1.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req_data[0] = 32'h4000_0000;
    req_data[1] = 32'hC040_0000;
    req_valid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("cont%0d_valid", k), {31'd0, resp_valid}, 32'd1);
      check($sformatf("cont%0d_id", k), {31'd0, resp_id}, k % 2);
      check($sformatf("cont%0d_data", k), resp_data,
            (k % 2 == 0) ? 32'h0000_0002 : 32'hFFFF_FFFD);
    end

    // Backpressure: last served was requester 1; hold for three cycles.
    resp_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_ready", k), {30'd0, req_ready}, 32'd0);
      step();
      check($sformatf("bp%0d_id", k), {31'd0, resp_id}, 32'd1);
      check($sformatf("bp%0d_data", k), resp_data, 32'hFFFF_FFFD);
      check($sformatf("bp%0d_valid", k), {31'd0, resp_valid}, 32'd1);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_release_ready", {30'd0, req_ready}, 32'd1);
    step();
    check("bp_release_id", {31'd0, resp_id}, 32'd0);
    check("bp_release_data", resp_data, 32'h0000_0002);

    // Reset while a result is held: valid drops at once, requester 0 wins after.
    resp_ready = 1'b0;
    step();
    check("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_ready", {30'd0, req_ready}, 32'd0);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("post_rst_ready", {30'd0, req_ready}, 32'd1);
    step();
    check("post_rst_id", {31'd0, resp_id}, 32'd0);
    check("post_rst_valid", {31'd0, resp_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
